sha3_state_serializer: RTL and testbench

SHA3_STATE_SERIALIZER -- requirements
Module: sha3_state_serializer

---
 rtl/sha3_pkg.sv | 35 +++
 rtl/sha3_state_serializer_if.sv | 26 ++
 rtl/sha3_lane_order_map.sv | 26 ++
 rtl/sha3_state_serializer.sv | 140 ++++++++++++++
 tb/tb_sha3_state_serializer.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sha3_pkg.sv
// Shared types, constants and small helpers for the SHA-3 state serializer.
package sha3_pkg;

    localparam int LANE_W    = 64;
    localparam int NUM_LANES = 25;
    localparam int DIM       = 5;

    // Beat number of the final lane of a state.
    localparam logic [4:0] LAST_BEAT = 5'(NUM_LANES - 1);

    typedef logic [LANE_W-1:0] lane_t;

    // One row of the state (fixed y); element index is x.
    typedef lane_t [DIM-1:0] row_t;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // Quotient of a beat number (0..24) by 5.
    function automatic logic [2:0] div5(input logic [4:0] b);
        if (b < 5'd5)       return 3'd0;
        else if (b < 5'd10) return 3'd1;
        else if (b < 5'd15) return 3'd2;
        else if (b < 5'd20) return 3'd3;
        else                return 3'd4;
    endfunction

    // Remainder of a beat number (0..24) by 5.
    function automatic logic [2:0] mod5(input logic [4:0] b);
        return 3'(b - {2'b00, div5(b)} * 5'd5);
    endfunction

endpackage

// File: rtl/sha3_state_serializer_if.sv
// Lane stream from the serializer to its consumer (valid/ready handshake).
interface sha3_state_serializer_if import sha3_pkg::*; ();

    logic       ovalid;
    logic       oready;
    lane_t      olane;
    logic [4:0] oindex;
    logic       olast;

    modport master (
        output ovalid,
        output olane,
        output oindex,
        output olast,
        input  oready
    );

    modport slave (
        input  ovalid,
        input  olane,
        input  oindex,
        input  olast,
        output oready
    );

endinterface

// File: rtl/sha3_lane_order_map.sv
// Maps a beat number to the (x, y) lane position and its linear index 5*y+x.
// "xfirst" walks x fastest within a row; "yfirst" walks y fastest within a column.
module sha3_lane_order_map import sha3_pkg::*; #(
    parameter LANE_ORDER = "xfirst"
) (
    input  logic [4:0] beat,
    output logic [2:0] x,
    output logic [2:0] y,
    output logic [4:0] index
);

    localparam bit Y_FIRST = (LANE_ORDER == "yfirst");

    // Split the beat into minor/major base-5 digits and assign them to x/y.
    always_comb begin
        if (Y_FIRST) begin
            y = mod5(beat);
            x = div5(beat);
        end else begin
            x = mod5(beat);
            y = div5(beat);
        end
        index = {2'b00, y} * 5'd5 + {2'b00, x};
    end

endmodule

// File: rtl/sha3_state_serializer.sv
// Captures a full 1600-bit Keccak state on a sample pulse and streams it out
// as 25 registered 64-bit lane beats over a valid/ready handshake.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no captured state pending; outputs hold last beat, ovalid low
// STREAM | captured state being emitted, one beat per accepted handshake
module sha3_state_serializer import sha3_pkg::*; #(
    parameter LANE_ORDER = "xfirst"
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  sample,
    input  row_t  isa,
    input  row_t  isb,
    input  row_t  isc,
    input  row_t  isd,
    input  row_t  ise,
    output logic  busy,
    output logic  overrun,
    sha3_state_serializer_if.master ostream
);

    state_t     state_q, state_d;
    logic [4:0] beat_q;
    logic [4:0] beat_nxt;
    row_t       lanes_q [DIM];

    logic       ovalid_q;
    lane_t      olane_q;
    logic [4:0] oindex_q;
    logic       olast_q;
    logic       overrun_q;

    logic       accept;
    logic       final_acc;
    logic       capture;
    logic       advance;
    logic       overrun_d;

    logic [2:0] map_x;
    logic [2:0] map_y;
    logic [4:0] map_index;

    // Counter saturates at the last beat so it never leaves 0..24.
    assign beat_nxt = (beat_q == LAST_BEAT) ? LAST_BEAT : beat_q + 5'd1;

    // Lookup for the beat that will be presented after the current one.
    sha3_lane_order_map #(
        .LANE_ORDER (LANE_ORDER)
    ) u_order_map (
        .beat  (beat_nxt),
        .x     (map_x),
        .y     (map_y),
        .index (map_index)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state and control decode; a sample on the final accepted beat
    // chains straight into the next state without a bubble.
    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        advance   = 1'b0;
        overrun_d = 1'b0;
        accept    = (state_q == STREAM) && ovalid_q && ostream.oready;
        final_acc = accept && (beat_q == LAST_BEAT);
        case (state_q)
            IDLE: begin
                if (sample) begin
                    capture = 1'b1;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (final_acc) begin
                    if (sample) capture = 1'b1;
                    else        state_d = IDLE;
                end else begin
                    advance   = accept;
                    overrun_d = sample;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Captured state; contents are only meaningful while streaming, so no reset.
    always_ff @(posedge clk) begin
        if (rst_n && capture) begin
            lanes_q[0] <= isa;
            lanes_q[1] <= isb;
            lanes_q[2] <= isc;
            lanes_q[3] <= isd;
            lanes_q[4] <= ise;
        end
    end

    // Output beat registers and beat counter. Beat 0 is lane (0,0) in either
    // order, so it is loaded straight from isa[0] to get single-cycle latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovalid_q  <= 1'b0;
            olane_q   <= '0;
            oindex_q  <= '0;
            olast_q   <= 1'b0;
            overrun_q <= 1'b0;
            beat_q    <= '0;
        end else begin
            overrun_q <= overrun_d;
            if (capture) begin
                ovalid_q <= 1'b1;
                beat_q   <= '0;
                olane_q  <= isa[0];
                oindex_q <= '0;
                olast_q  <= 1'b0;
            end else if (advance) begin
                beat_q   <= beat_nxt;
                olane_q  <= lanes_q[map_y][map_x];
                oindex_q <= map_index;
                olast_q  <= (beat_nxt == LAST_BEAT);
            end else if (final_acc) begin
                ovalid_q <= 1'b0;
            end
        end
    end

    assign busy           = (state_q == STREAM);
    assign overrun        = overrun_q;
    assign ostream.ovalid = ovalid_q;
    assign ostream.olane  = olane_q;
    assign ostream.oindex = oindex_q;
    assign ostream.olast  = olast_q;

endmodule

// File: tb/tb_sha3_state_serializer.sv
// Bench for sha3_state_serializer: one xfirst and one yfirst instance share
// stimulus; a scoreboard per instance holds the expected beat stream.
module tb_sha3_state_serializer;
    import sha3_pkg::*;

    typedef struct {
        logic [4:0] idx;
        lane_t      lane;
        logic       last;
    } beat_t;

    typedef struct {
        int         cyc;
        logic       ovalid;
        logic [4:0] oindex;
        lane_t      olane;
        logic       olast;
        logic       busy;
        logic [4:0] yidx;
    } vec_t;

    logic  clk    = 1'b0;
    logic  rst_n  = 1'b0;
    logic  sample = 1'b0;
    logic  rdy    = 1'b1;
    row_t  isa, isb, isc, isd, ise;
    logic  busy_x, overrun_x, busy_y, overrun_y;

    int    cyc      = 0;
    int    n_checks = 0;
    int    n_fail   = 0;
    int    beats_x  = 0;

    beat_t sbq_x[$];
    beat_t sbq_y[$];

    logic       stall_x = 1'b0;
    lane_t      held_lane;
    logic [4:0] held_idx;
    logic       held_last;

    sha3_state_serializer_if bus_x();
    sha3_state_serializer_if bus_y();

    assign bus_x.oready = rdy;
    assign bus_y.oready = rdy;

    sha3_state_serializer #(.LANE_ORDER("xfirst")) dut_x (
        .clk     (clk),
        .rst_n   (rst_n),
        .sample  (sample),
        .isa     (isa),
        .isb     (isb),
        .isc     (isc),
        .isd     (isd),
        .ise     (ise),
        .busy    (busy_x),
        .overrun (overrun_x),
        .ostream (bus_x)
    );

    sha3_state_serializer #(.LANE_ORDER("yfirst")) dut_y (
        .clk     (clk),
        .rst_n   (rst_n),
        .sample  (sample),
        .isa     (isa),
        .isb     (isb),
        .isc     (isc),
        .isd     (isd),
        .ise     (ise),
        .busy    (busy_y),
        .overrun (overrun_y),
        .ostream (bus_y)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic lane_t pat(int p, int x, int y);
        case (p)
            0:       return {4'(y), 4'(x), 56'h0};
            1:       return {4'(y), 4'(x), 56'h5A5A_5A5A_5A5A_5A};
            default: return {4'(y), 4'(x), 56'hFF00_00FF_FF00_00} ^ 64'h1234;
        endcase
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic load_state(int p);
        for (int x = 0; x < 5; x++) begin
            isa[x] = pat(p, x, 0);
            isb[x] = pat(p, x, 1);
            isc[x] = pat(p, x, 2);
            isd[x] = pat(p, x, 3);
            ise[x] = pat(p, x, 4);
        end
    endtask

    task automatic push_expected(int p);
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                sbq_x.push_back('{5'(5*y+x), pat(p, x, y), (x == 4 && y == 4)});
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                sbq_y.push_back('{5'(5*y+x), pat(p, x, y), (x == 4 && y == 4)});
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_cycle(int n);
        while (cyc < n) next_cycle();
    endtask

    // Drives sample for exactly one cycle, then scrambles the inputs.
    task automatic pulse(int p, bit expect_accept);
        load_state(p);
        sample = 1'b1;
        if (expect_accept) push_expected(p);
        next_cycle();
        sample = 1'b0;
        load_state(2);
    endtask

    task automatic wait_idle(string name);
        int k;
        k = 0;
        while ((busy_x || busy_y) && k < 100) begin
            next_cycle();
            k++;
        end
        check(name, busy_x | busy_y, 1'b0);
    endtask

    // Scoreboard pop on every accepted beat plus hold check across stalls.
    always @(negedge clk) begin
        beat_t e;
        if (rst_n && bus_x.ovalid && rdy) begin
            check("x_beat_expected", sbq_x.size() > 0, 1'b1);
            if (sbq_x.size() > 0) begin
                e = sbq_x.pop_front();
                check("x_oindex", bus_x.oindex, e.idx);
                check("x_olane", bus_x.olane, e.lane);
                check("x_olast", bus_x.olast, e.last);
            end
            beats_x <= beats_x + 1;
        end
        if (rst_n && bus_y.ovalid && rdy) begin
            check("y_beat_expected", sbq_y.size() > 0, 1'b1);
            if (sbq_y.size() > 0) begin
                e = sbq_y.pop_front();
                check("y_oindex", bus_y.oindex, e.idx);
                check("y_olane", bus_y.olane, e.lane);
                check("y_olast", bus_y.olast, e.last);
            end
        end
        if (rst_n && stall_x && bus_x.ovalid) begin
            check("x_hold_olane", bus_x.olane, held_lane);
            check("x_hold_oindex", bus_x.oindex, held_idx);
            check("x_hold_olast", bus_x.olast, held_last);
        end
        stall_x   <= rst_n && bus_x.ovalid && !rdy;
        held_lane <= bus_x.olane;
        held_idx  <= bus_x.oindex;
        held_last <= bus_x.olast;
    end

    initial begin
        repeat (5000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        int   s;
        int   b0;
        int   k;

        tbl[0] = '{11, 1'b1, 5'd0,  pat(0, 0, 0), 1'b0, 1'b1, 5'd0};
        tbl[1] = '{12, 1'b1, 5'd1,  pat(0, 1, 0), 1'b0, 1'b1, 5'd5};
        tbl[2] = '{23, 1'b1, 5'd12, pat(0, 2, 2), 1'b0, 1'b1, 5'd12};
        tbl[3] = '{34, 1'b1, 5'd23, pat(0, 3, 4), 1'b0, 1'b1, 5'd19};
        tbl[4] = '{35, 1'b1, 5'd24, pat(0, 4, 4), 1'b1, 1'b1, 5'd24};
        tbl[5] = '{36, 1'b0, 5'd24, pat(0, 4, 4), 1'b1, 1'b0, 5'd24};
        tbl[6] = '{40, 1'b0, 5'd24, pat(0, 4, 4), 1'b1, 1'b0, 5'd24};

        load_state(2);
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("rst_ovalid", bus_x.ovalid, 1'b0);
        check("rst_olane", bus_x.olane, 64'h0);
        check("rst_oindex", bus_x.oindex, 5'd0);
        check("rst_olast", bus_x.olast, 1'b0);
        check("rst_overrun", overrun_x, 1'b0);
        check("rst_busy", busy_x, 1'b0);
        check("rst_busy_y", busy_y, 1'b0);
        next_cycle();
        rst_n = 1'b1;

        // Basic stream, oready held high, sample in cycle 10.
        goto_cycle(10);
        pulse(0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            goto_cycle(tbl[i].cyc);
            @(negedge clk);
            check("tbl_ovalid", bus_x.ovalid, tbl[i].ovalid);
            check("tbl_oindex", bus_x.oindex, tbl[i].oindex);
            check("tbl_olane", bus_x.olane, tbl[i].olane);
            check("tbl_olast", bus_x.olast, tbl[i].olast);
            check("tbl_busy", busy_x, tbl[i].busy);
            check("tbl_overrun", overrun_x, 1'b0);
            check("tbl_y_oindex", bus_y.oindex, tbl[i].yidx);
        end

        // oready toggling 1/0: 25 beats over 49 cycles.
        next_cycle();
        pulse(0, 1'b1);
        s  = cyc - 1;
        b0 = beats_x;
        k  = 0;
        while (busy_x && k < 100) begin
            rdy = ((cyc - s - 1) % 2 == 0);
            next_cycle();
            k++;
        end
        rdy = 1'b1;
        check("stall_done_cycle", cyc - s, 50);
        check("stall_beat_count", beats_x - b0, 25);

        // Back-to-back: second sample on the final accepted beat.
        next_cycle();
        pulse(0, 1'b1);
        s = cyc - 1;
        goto_cycle(s + 25);
        check("b2b_pre_olast", bus_x.olast, 1'b1);
        pulse(1, 1'b1);
        @(negedge clk);
        check("b2b_ovalid", bus_x.ovalid, 1'b1);
        check("b2b_oindex", bus_x.oindex, 5'd0);
        check("b2b_olane", bus_x.olane, pat(1, 0, 0));
        check("b2b_busy", busy_x, 1'b1);
        check("b2b_overrun", overrun_x, 1'b0);
        next_cycle();
        @(negedge clk);
        check("b2b_overrun_next", overrun_x, 1'b0);
        check("b2b_oindex_next", bus_x.oindex, 5'd1);
        wait_idle("b2b_idle");

        // Sample during beat 7 is dropped and flagged.
        next_cycle();
        pulse(0, 1'b1);
        s = cyc - 1;
        goto_cycle(s + 8);
        check("ovr_pre_oindex", bus_x.oindex, 5'd7);
        pulse(1, 1'b0);
        @(negedge clk);
        check("ovr_pulse", overrun_x, 1'b1);
        check("ovr_pulse_y", overrun_y, 1'b1);
        check("ovr_oindex", bus_x.oindex, 5'd8);
        check("ovr_olane", bus_x.olane, pat(0, 3, 1));
        next_cycle();
        @(negedge clk);
        check("ovr_pulse_end", overrun_x, 1'b0);
        wait_idle("ovr_idle");

        // Reset at beat 12 with a sample in the same cycle.
        next_cycle();
        pulse(0, 1'b1);
        s = cyc - 1;
        goto_cycle(s + 13);
        rst_n  = 1'b0;
        sample = 1'b1;
        load_state(1);
        @(negedge clk);
        sbq_x.delete();
        sbq_y.delete();
        next_cycle();
        rst_n  = 1'b1;
        sample = 1'b0;
        load_state(2);
        @(negedge clk);
        check("rst12_ovalid", bus_x.ovalid, 1'b0);
        check("rst12_busy", busy_x, 1'b0);
        check("rst12_busy_y", busy_y, 1'b0);
        check("rst12_oindex", bus_x.oindex, 5'd0);
        check("rst12_olane", bus_x.olane, 64'h0);
        check("rst12_overrun", overrun_x, 1'b0);
        next_cycle();
        @(negedge clk);
        check("rst12_no_capture", bus_x.ovalid | bus_y.ovalid, 1'b0);
        next_cycle();
        pulse(1, 1'b1);
        @(negedge clk);
        check("rst12_fresh_ovalid", bus_x.ovalid, 1'b1);
        check("rst12_fresh_oindex", bus_x.oindex, 5'd0);
        check("rst12_fresh_olane", bus_x.olane, pat(1, 0, 0));
        wait_idle("rst12_idle");

        next_cycle();
        next_cycle();
        check("sb_x_empty", sbq_x.size(), 0);
        check("sb_y_empty", sbq_y.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
